// File: rtl/watch_pkg.sv
// Shared definitions for the digital watch controller: FSM encodings,
// rollover limits for the minute and second fields, and a helper that turns
// a small integer into its two-digit BCD form.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } watch_state_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Convert 0..99 into packed BCD {tens, ones}
    function automatic logic [7:0] to_bcd(input int value);
        to_bcd = {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

// File: rtl/watch_bcd_pair.sv
// Two-digit BCD counter used for the seconds, minutes and hours fields.
// Counts 00..max_val and wraps to 00; carry pulses while enabled at max_val so
// the next field can advance on the same clock edge. clr beats en.
module watch_bcd_pair
    import watch_pkg::*;
(
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] max_val,
    output logic [3:0] digit_l,
    output logic [3:0] digit_h,
    output logic       carry
);

    logic at_max;

    // Anything at or beyond the limit is treated as the wrap point, so a
    // field can never leave its legal range even if max_val changes.
    assign at_max = ({digit_h, digit_l} >= max_val);
    assign carry  = en & at_max;

    // Digit registers: clear first, then BCD increment with wrap
    always_ff @(posedge CLK_IN) begin
        if (RST || clr) begin
            digit_l <= 4'd0;
            digit_h <= 4'd0;
        end else if (en) begin
            if (at_max) begin
                digit_l <= 4'd0;
                digit_h <= 4'd0;
            end else if (digit_l >= 4'd9) begin
                digit_l <= 4'd0;
                digit_h <= digit_h + 4'd1;
            end else begin
                digit_l <= digit_l + 4'd1;
            end
        end
    end

endmodule

// File: rtl/watch_ctrl.sv
// Digital watch controller: runs a BCD clock from a 1 Hz tick and lets the
// user set hours and minutes with a mode button and an increment button.
// Holds the mode FSM, the button edge detectors and the blink flag.
module watch_ctrl
    import watch_pkg::*;
#(
    parameter int HOUR_MAX = 23
) (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       TICK,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    output logic [3:0] SEC_L,
    output logic [3:0] SEC_H,
    output logic [3:0] MIN_L,
    output logic [3:0] MIN_H,
    output logic [3:0] HR_L,
    output logic [3:0] HR_H,
    output logic [1:0] MODE,
    output logic       BLINK,
    output logic       DAY_CARRY
);

    localparam logic [7:0] SEC_MAX_BCD = to_bcd(SEC_MAX);
    localparam logic [7:0] MIN_MAX_BCD = to_bcd(MIN_MAX);
    localparam logic [7:0] HR_MAX_BCD  = to_bcd(HOUR_MAX);

    watch_state_t state_q, state_d;
    logic mode_prev, inc_prev;
    logic mode_edge, inc_edge;
    logic blink_d;
    logic run_tick, set_hr_inc, set_min_inc, sec_clr;
    logic sec_en, min_en, hr_en;
    logic sec_carry, min_carry, hr_carry;

    assign mode_edge = BTN_MODE & ~mode_prev;
    assign inc_edge  = BTN_INC & ~inc_prev;

    // State, blink, day pulse and button history; previous values start high
    // so a button already held during reset never looks like a fresh press.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_q   <= RUN;
            BLINK     <= 1'b0;
            DAY_CARRY <= 1'b0;
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
        end else begin
            state_q   <= state_d;
            BLINK     <= blink_d;
            DAY_CARRY <= run_tick & hr_carry;
            mode_prev <= BTN_MODE;
            inc_prev  <= BTN_INC;
        end
    end

    // Next state plus the per-mode counting requests; a mode press always
    // wins over an increment press, but a tick in RUN still counts.
    always_comb begin
        state_d     = state_q;
        blink_d     = BLINK;
        run_tick    = 1'b0;
        set_hr_inc  = 1'b0;
        set_min_inc = 1'b0;
        sec_clr     = 1'b0;
        case (state_q)
            RUN: begin
                run_tick = TICK;
                blink_d  = 1'b0;
                if (mode_edge) begin
                    state_d = SET_HR;
                    sec_clr = 1'b1;
                    blink_d = 1'b1;
                end
            end
            SET_HR: begin
                sec_clr = 1'b1;
                if (mode_edge) begin
                    state_d = SET_MIN;
                    blink_d = 1'b1;
                end else begin
                    set_hr_inc = inc_edge;
                    if (TICK) blink_d = ~BLINK;
                end
            end
            SET_MIN: begin
                sec_clr = 1'b1;
                if (mode_edge) begin
                    state_d = RUN;
                    blink_d = 1'b0;
                end else begin
                    set_min_inc = inc_edge;
                    if (TICK) blink_d = ~BLINK;
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    // Carries ripple only while running; set-mode increments stay local
    assign sec_en = run_tick;
    assign min_en = (run_tick & sec_carry) | set_min_inc;
    assign hr_en  = (run_tick & sec_carry & min_carry) | set_hr_inc;

    assign MODE = state_q;

    watch_bcd_pair u_sec (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .en     (sec_en),
        .clr    (sec_clr),
        .max_val(SEC_MAX_BCD),
        .digit_l(SEC_L),
        .digit_h(SEC_H),
        .carry  (sec_carry)
    );

    watch_bcd_pair u_min (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .en     (min_en),
        .clr    (1'b0),
        .max_val(MIN_MAX_BCD),
        .digit_l(MIN_L),
        .digit_h(MIN_H),
        .carry  (min_carry)
    );

    watch_bcd_pair u_hr (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .en     (hr_en),
        .clr    (1'b0),
        .max_val(HR_MAX_BCD),
        .digit_l(HR_L),
        .digit_h(HR_H),
        .carry  (hr_carry)
    );

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed bench for watch_ctrl: walks the set path, rollover, button
// priority, held-button and reset cases with hand-computed expected times.
module tb_watch_ctrl;

    logic       CLK_IN = 1'b0;
    logic       RST = 1'b1;
    logic       TICK = 1'b0;
    logic       BTN_MODE = 1'b0;
    logic       BTN_INC = 1'b0;
    logic [3:0] SEC_L, SEC_H, MIN_L, MIN_H, HR_L, HR_H;
    logic [1:0] MODE;
    logic       BLINK;
    logic       DAY_CARRY;

    int total = 0;
    int bad = 0;

    watch_ctrl #(.HOUR_MAX(23)) dut (
        .CLK_IN   (CLK_IN),
        .RST      (RST),
        .TICK     (TICK),
        .BTN_MODE (BTN_MODE),
        .BTN_INC  (BTN_INC),
        .SEC_L    (SEC_L),
        .SEC_H    (SEC_H),
        .MIN_L    (MIN_L),
        .MIN_H    (MIN_H),
        .HR_L     (HR_L),
        .HR_H     (HR_H),
        .MODE     (MODE),
        .BLINK    (BLINK),
        .DAY_CARRY(DAY_CARRY)
    );

    // 10 ns clock
    always #5 CLK_IN = ~CLK_IN;

    function automatic logic [23:0] curTime();
        return {HR_H, HR_L, MIN_H, MIN_L, SEC_H, SEC_L};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the current inputs, then settle 1 ns past it
    task automatic clockCycle();
        @(posedge CLK_IN);
        #1;
    endtask

    // One-cycle pulse of the given inputs, then everything back low
    task automatic applyStimulus(input logic tick, input logic mode, input logic inc, input logic rst);
        TICK = tick;
        BTN_MODE = mode;
        BTN_INC = inc;
        RST = rst;
        clockCycle();
        TICK = 1'b0;
        BTN_MODE = 1'b0;
        BTN_INC = 1'b0;
        RST = 1'b0;
    endtask

    task automatic pressInc(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            clockCycle();
        end
    endtask

    task automatic pressMode();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        clockCycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset with BTN_MODE held high throughout
        RST = 1'b1;
        BTN_MODE = 1'b1;
        clockCycle();
        clockCycle();
        checkOutput("rst_time", 32'(curTime()), 32'h000000);
        checkOutput("rst_mode", 32'(MODE), 32'd0);
        checkOutput("rst_blink", 32'(BLINK), 32'd0);
        checkOutput("rst_daycarry", 32'(DAY_CARRY), 32'd0);

        // Release reset, keep BTN_MODE high: no edge, stays RUN
        RST = 1'b0;
        repeat (3) clockCycle();
        checkOutput("held_mode_run", 32'(MODE), 32'd0);
        TICK = 1'b1;
        clockCycle();
        TICK = 1'b0;
        checkOutput("held_first_tick", 32'(curTime()), 32'h000001);
        checkOutput("held_mode_still_run", 32'(MODE), 32'd0);
        BTN_MODE = 1'b0;
        clockCycle();

        // Enter SET_HR: seconds cleared, blink on
        pressMode();
        checkOutput("sethr_mode", 32'(MODE), 32'd1);
        checkOutput("sethr_time", 32'(curTime()), 32'h000000);
        checkOutput("sethr_blink", 32'(BLINK), 32'd1);

        // Ticks in SET_HR toggle blink and leave time alone
        ticks(1);
        checkOutput("sethr_blink_tog0", 32'(BLINK), 32'd0);
        checkOutput("sethr_tick_hold", 32'(curTime()), 32'h000000);
        ticks(1);
        checkOutput("sethr_blink_tog1", 32'(BLINK), 32'd1);

        // BTN_INC held 100 cycles: exactly one increment
        BTN_INC = 1'b1;
        repeat (100) clockCycle();
        BTN_INC = 1'b0;
        clockCycle();
        checkOutput("inc_held_once", 32'(curTime()), 32'h010000);

        // Hours up to 23, then wrap to 00 with no day carry
        pressInc(22);
        checkOutput("hr_at_23", 32'(curTime()), 32'h230000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hr_wrap", 32'(curTime()), 32'h000000);
        checkOutput("hr_wrap_nodc", 32'(DAY_CARRY), 32'd0);
        clockCycle();
        pressInc(23);
        checkOutput("hr_back_23", 32'(curTime()), 32'h230000);

        // Simultaneous mode and inc in SET_HR: mode wins, hours unchanged
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("modeinc_mode", 32'(MODE), 32'd2);
        checkOutput("modeinc_hours", 32'(curTime()), 32'h230000);
        checkOutput("setmin_blink", 32'(BLINK), 32'd1);
        clockCycle();

        // Minutes to 59, wrap to 00 without touching hours
        pressInc(59);
        checkOutput("min_at_59", 32'(curTime()), 32'h235900);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("min_wrap", 32'(curTime()), 32'h230000);
        checkOutput("min_wrap_nodc", 32'(DAY_CARRY), 32'd0);
        clockCycle();
        pressInc(59);
        checkOutput("min_back_59", 32'(curTime()), 32'h235900);

        // Back to RUN, resume counting from the set value
        pressMode();
        checkOutput("run_mode", 32'(MODE), 32'd0);
        checkOutput("run_blink", 32'(BLINK), 32'd0);
        ticks(1);
        checkOutput("resume_tick", 32'(curTime()), 32'h235901);
        ticks(57);
        checkOutput("at_235958", 32'(curTime()), 32'h235958);
        ticks(1);
        checkOutput("at_235959", 32'(curTime()), 32'h235959);
        checkOutput("dc_before_wrap", 32'(DAY_CARRY), 32'd0);
        ticks(1);
        checkOutput("day_wrap", 32'(curTime()), 32'h000000);
        checkOutput("dc_pulse", 32'(DAY_CARRY), 32'd1);
        clockCycle();
        checkOutput("dc_one_cycle", 32'(DAY_CARRY), 32'd0);

        // Preload 10:20 via the set path, then run to 10:20:30
        pressMode();
        pressInc(10);
        pressMode();
        pressInc(20);
        pressMode();
        ticks(30);
        checkOutput("at_102030", 32'(curTime()), 32'h102030);

        // BTN_INC ignored in RUN
        pressInc(1);
        checkOutput("run_inc_ignored", 32'(curTime()), 32'h102030);

        // Simultaneous mode and tick in RUN: seconds cleared, SET_HR
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("modetick_mode", 32'(MODE), 32'd1);
        checkOutput("modetick_time", 32'(curTime()), 32'h102000);
        checkOutput("modetick_blink", 32'(BLINK), 32'd1);
        clockCycle();

        // Reset mid-set with every other input active
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("midrst_time", 32'(curTime()), 32'h000000);
        checkOutput("midrst_mode", 32'(MODE), 32'd0);
        checkOutput("midrst_blink", 32'(BLINK), 32'd0);
        checkOutput("midrst_dc", 32'(DAY_CARRY), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
